// File: rtl/masked_serial_adder.sv
// masked_serial_adder
// Bit-serial adder over two Boolean shares. Each operand bit takes two
// cycles: GEN registers the domain-oriented-masking (DOM) AND terms for
// the generate term g = a&b and the propagate term t = c&(a^b); COMP folds
// those terms into the new carry shares and writes one sum bit per share.
// The shares of a value are never XORed together anywhere in the datapath.
//
// Optional feature: define ADDER_COUT_EN to add the carry-out share ports
// o_Cout0/o_Cout1. Without it the final carry is simply dropped.
//
// WIDTH is intended for the range 1..64.
module masked_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_A0,
    input  logic [WIDTH-1:0] i_A1,
    input  logic [WIDTH-1:0] i_B0,
    input  logic [WIDTH-1:0] i_B1,
    input  logic             i_Cin0,
    input  logic             i_Cin1,
    input  logic [1:0]       i_r,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_Sum0,
    output logic [WIDTH-1:0] o_Sum1
`ifdef ADDER_COUT_EN
    ,
    output logic             o_Cout0,
    output logic             o_Cout1
`endif
);

    // Bit index width; a 1-bit operand still needs a 1-bit counter.
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        COMP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Latched operand shares and the sum under construction, one word per share.
    logic [WIDTH-1:0] a_reg   [2];
    logic [WIDTH-1:0] b_reg   [2];
    logic [WIDTH-1:0] sum_reg [2];
    logic [WIDTH-1:0] sum_upd [2];

    logic [KW-1:0] k_reg;

    // Carry shares, index = share domain.
    logic [1:0] c_reg;

    // Registered DOM terms: inner-domain products and refreshed cross products.
    logic [1:0] g_in_reg;
    logic [1:0] g_x_reg;
    logic [1:0] t_in_reg;
    logic [1:0] t_x_reg;

    // Per-domain combinational signals for the current bit.
    logic [1:0] a_bit;
    logic [1:0] b_bit;
    logic [1:0] p_bit;
    logic [1:0] g_in_w;
    logic [1:0] g_x_w;
    logic [1:0] t_in_w;
    logic [1:0] t_x_w;
    logic [1:0] g_sh;
    logic [1:0] t_sh;
    logic [1:0] c_new;
    logic [1:0] s_bit;

    // One slice per share domain. Cross terms pair this domain's x with the
    // other domain's y and are refreshed by the gadget's random bit before
    // they reach a register; recombination happens only from registers.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_domain
            assign a_bit[gi]  = a_reg[gi][k_reg];
            assign b_bit[gi]  = b_reg[gi][k_reg];
            assign p_bit[gi]  = a_bit[gi] ^ b_bit[gi];

            assign g_in_w[gi] = a_bit[gi] & b_bit[gi];
            assign g_x_w[gi]  = (a_bit[gi] & b_bit[1-gi]) ^ i_r[0];
            assign t_in_w[gi] = c_reg[gi] & p_bit[gi];
            assign t_x_w[gi]  = (c_reg[gi] & p_bit[1-gi]) ^ i_r[1];

            assign g_sh[gi]   = g_in_reg[gi] ^ g_x_reg[gi];
            assign t_sh[gi]   = t_in_reg[gi] ^ t_x_reg[gi];
            // g and c&p are never both 1, so OR reduces to XOR share-wise.
            assign c_new[gi]  = g_sh[gi] ^ t_sh[gi];
            assign s_bit[gi]  = p_bit[gi] ^ c_reg[gi];
        end
    endgenerate

    // Sum words with bit k replaced by the freshly computed sum share.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            sum_upd[i]        = sum_reg[i];
            sum_upd[i][k_reg] = s_bit[i];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state_reg;
        i_ready    = 1'b0;
        o_valid    = 1'b0;
        case (state_reg)
            IDLE: begin
                i_ready = 1'b1;
                if (i_valid) begin
                    state_next = GEN;
                end
            end
            GEN: begin
                state_next = COMP;
            end
            COMP: begin
                if (k_reg == K_LAST) begin
                    state_next = DONE;
                end else begin
                    state_next = GEN;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (o_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, DOM term registers, carry/sum update and
    // the output registers, which are loaded only when the last bit completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_reg      <= '0;
            a_reg[0]   <= '0;
            a_reg[1]   <= '0;
            b_reg[0]   <= '0;
            b_reg[1]   <= '0;
            sum_reg[0] <= '0;
            sum_reg[1] <= '0;
            c_reg      <= '0;
            g_in_reg   <= '0;
            g_x_reg    <= '0;
            t_in_reg   <= '0;
            t_x_reg    <= '0;
            o_Sum0     <= '0;
            o_Sum1     <= '0;
`ifdef ADDER_COUT_EN
            o_Cout0    <= 1'b0;
            o_Cout1    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_valid) begin
                        a_reg[0] <= i_A0;
                        a_reg[1] <= i_A1;
                        b_reg[0] <= i_B0;
                        b_reg[1] <= i_B1;
                        c_reg    <= {i_Cin1, i_Cin0};
                        k_reg    <= '0;
                    end
                end
                GEN: begin
                    g_in_reg <= g_in_w;
                    g_x_reg  <= g_x_w;
                    t_in_reg <= t_in_w;
                    t_x_reg  <= t_x_w;
                end
                COMP: begin
                    sum_reg[0] <= sum_upd[0];
                    sum_reg[1] <= sum_upd[1];
                    c_reg      <= c_new;
                    if (k_reg == K_LAST) begin
                        o_Sum0  <= sum_upd[0];
                        o_Sum1  <= sum_upd[1];
`ifdef ADDER_COUT_EN
                        o_Cout0 <= c_new[0];
                        o_Cout1 <= c_new[1];
`endif
                    end else begin
                        k_reg <= k_reg + KW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/masked_serial_adder.md
MASKED_SERIAL_ADDER -- requirements
Module: masked_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand bit count; legal range 1..64.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port i_valid, input, 1: operand shares and carry-in shares are valid this cycle.
REQ-005 SHALL have port i_ready, output, 1: the block accepts operands this cycle.
REQ-006 SHALL have ports i_A0, i_A1, input, WIDTH: the two Boolean shares of A (A = i_A0 ^ i_A1).
REQ-007 SHALL have ports i_B0, i_B1, input, WIDTH: the two Boolean shares of B.
REQ-008 SHALL have ports i_Cin0, i_Cin1, input, 1: the two shares of carry-in.
REQ-009 SHALL have port i_r, input, 2: fresh randomness, one bit per DOM AND gadget.
REQ-010 SHALL have port o_valid, output, 1: result shares are valid.
REQ-011 SHALL have port o_ready, input, 1: the consumer accepts the result.
REQ-012 SHALL have ports o_Sum0, o_Sum1, output, WIDTH, registered: the two shares of (A+B+Cin) mod 2^WIDTH.
REQ-013 SHALL have ports o_Cout0, o_Cout1, output, 1, registered: carry-out shares; these ports exist only under ADDER_COUT_EN.

Function
REQ-014 SHALL implement an FSM with states IDLE, GEN, COMP, DONE.
REQ-015 In IDLE, i_ready SHALL be 1; on i_valid=1, the FSM SHALL latch all input shares, set bit index k=0, load the carry shares from i_Cin0/1, and go to GEN.
REQ-016 GEN (bit k) SHALL compute g = a_k&b_k and t = c&p with p = a_k^b_k, each as a 2-share DOM-independent AND.
REQ-017 In GEN, the cross terms x0y1^r and x1y0^r SHALL be registered using i_r[0] for g and i_r[1] for t; the inner-domain terms SHALL also be registered.
REQ-018 No combinational path SHALL recombine the shares of one domain with unregistered cross-domain terms.
REQ-019 COMP SHALL compress the registered terms into g0/g1 and t0/t1.
REQ-020 COMP SHALL write sum bit k per share as a_k^b_k^c (share-wise).
REQ-021 COMP SHALL update the carry shares to c_j = g_j ^ t_j.
REQ-022 In COMP, if k = WIDTH-1 the FSM SHALL go to DONE; otherwise it SHALL increment k and go to GEN.
REQ-023 Latency from the accepting cycle to the first o_valid=1 cycle SHALL be exactly 2*WIDTH+1 cycles.
REQ-024 i_ready SHALL be 0 in GEN, COMP and DONE, and i_valid SHALL be ignored in those states.
REQ-025 In DONE, o_valid SHALL be 1 and the outputs SHALL be held stable until o_ready=1; the FSM then SHALL return to IDLE on the next edge.
REQ-026 A new operand SHALL be accepted no earlier than the cycle after the DONE handshake; there is no overlap.
REQ-027 Unmasked values SHALL never be formed in any register or wire.
REQ-028 i_r SHALL be sampled only in GEN and SHALL be ignored in all other states.
REQ-029 For WIDTH=1, the FSM SHALL make exactly one GEN/COMP pass.

Reset
REQ-030 On rst=1, the FSM SHALL go to IDLE with k=0, o_valid=0, and o_Sum0/1=0, o_Cout0/1=0, carry shares=0 and all DOM term registers=0.
REQ-031 rst SHALL take priority over every other event.
REQ-032 Reset in any state, including mid-operation, SHALL abort the operation with no partial result ever presented.
REQ-033 i_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-034 With ADDER_COUT_EN defined, the final carry shares SHALL be registered into o_Cout0/1 at the COMP to DONE transition and held with the sum.
REQ-035 Without ADDER_COUT_EN, the o_Cout0/1 ports and their registers SHALL be absent; the carry is discarded and timing is unchanged.

Verification
REQ-036 WIDTH=8, A=0x5A, B=0x3C, Cin=0, random share splits -> Sum shares XOR to 0x96, Cout=0, o_valid at cycle 17 after accept.
REQ-037 WIDTH=8, A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1 (with ADDER_COUT_EN); repeat with Cin=1, B=0x00 -> Sum=0x00, Cout=1.
REQ-038 o_ready held 0 for 5 cycles in DONE -> o_valid stays 1, shares unchanged, i_ready stays 0; release -> i_ready=1 one cycle later.
REQ-039 rst pulsed during GEN of bit 3 -> next cycle in IDLE, o_valid=0, all outputs 0; the following operation A=0x01, B=0x01 -> Sum=0x02.
REQ-040 WIDTH=1, all 8 combinations of A, B, Cin with i_r randomised -> Sum/Cout match a 1-bit full adder, latency 3.
REQ-041 1000 random back-to-back operations with o_ready=1 and i_valid=1 -> every result correct, one accept per 2*WIDTH+2 cycles.
